// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed MAC controller for a TAPS-tap FIR: one shared signed multiplier,
// accumulation through an external 16-bit adder port, one output per accepted sample.
//
// state | meaning
// IDLE  | ready for a sample or a coefficient write; flush clears the delay line
// MAC   | one tap per cycle: acc <= add_o[15:0] of acc + x[tap]*coef[tap]
// DONE  | result held on out_data until out_ready
module fir_tap_scheduler #(
  parameter int             TAPS      = 4,
  parameter int             N         = 8,
  parameter logic [N-1:0]   COEF_INIT = 'h20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [N-1:0] cfg_data,
  output logic         cfg_err,
  input  logic         flush,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  input  logic [16:0]  add_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                state, state_nxt;
  logic signed [N-1:0]   x_line [TAPS];
  logic signed [N-1:0]   coef   [TAPS];
  logic [15:0]           acc;
  logic [TW-1:0]         tap;
  logic signed [2*N-1:0] prod;
  logic                  accept;
  logic                  cfg_ok;
  logic                  last_tap;
  logic                  add_o_unused;

  // The adder carry-out is deliberately dropped: the accumulator wraps at 16 bits.
  assign add_o_unused = add_o[16];

  assign accept   = in_valid && (state == IDLE);
  assign cfg_ok   = (state == IDLE) && !accept && (int'(cfg_addr) < TAPS);
  assign last_tap = (tap == TW'(TAPS - 1));
  assign prod     = x_line[tap] * coef[tap];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    add_a     = '0;
    add_b     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = MAC;
      end
      MAC: begin
        add_a = acc;
        add_b = 16'(prod);
        if (last_tap) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      tap     <= '0;
      cfg_err <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_line[k] <= '0;
        coef[k]   <= COEF_INIT;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;

      // Flush clears the line first, so a coincident sample lands in an empty line.
      if (state == IDLE && (flush || accept)) begin
        x_line[0] <= accept ? in_data : '0;
        for (int k = 1; k < TAPS; k++)
          x_line[k] <= flush ? '0 : x_line[k-1];
      end

      if (accept) begin
        acc <= '0;
        tap <= '0;
      end else if (state == MAC) begin
        acc <= add_o[15:0];
        tap <= last_tap ? '0 : tap + TW'(1);
      end

      if (cfg_we && cfg_ok)
        coef[cfg_addr[TW-1:0]] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench for fir_tap_scheduler: directed samples push expected outputs,
// a monitor pops and compares on every completed output handshake.
module tb_fir_tap_scheduler;
  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        cfg_we, cfg_err;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        flush;
  logic [15:0] add_a, add_b;
  logic [16:0] add_o;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        approx_mode = 1'b0;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  fir_tap_scheduler #(.TAPS(TAPS), .N(8), .COEF_INIT(8'h20)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .flush(flush),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Approximate adder: low 4 bits ORed, upper 12 bits added exactly with no carry-in.
  function automatic logic [16:0] approx_add(input logic [15:0] a, input logic [15:0] b);
    logic [12:0] hi;
    hi = {1'b0, a[15:4]} + {1'b0, b[15:4]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  assign add_o = approx_mode ? approx_add(add_a, add_b) : ({1'b0, add_a} + {1'b0, add_b});

  function automatic logic [15:0] model(input logic signed [7:0] xs[4],
                                        input logic signed [7:0] cs[4]);
    logic [15:0]        a;
    logic signed [15:0] p;
    logic [16:0]        s;
    a = '0;
    for (int k = 0; k < 4; k++) begin
      p = xs[k] * cs[k];
      s = approx_add(a, p);
      a = s[15:0];
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic fl, input bit push, input logic [15:0] e);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    if (push) exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic signed [7:0] lm[4];
    logic signed [7:0] cm[4];
    logic [7:0]        samp[4];
    logic [15:0]       e;
    int                lat;
    int                n;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready",  {31'h0, in_ready},  32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {16'h0, out_data},  32'd0);
    check("rst_cfg_err",   {31'h0, cfg_err},   32'd0);
    check("rst_add_a",     {16'h0, add_a},     32'd0);
    check("rst_add_b",     {16'h0, add_b},     32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Moving average of a constant 4 ramps up as the line fills.
    samp = '{8'd4, 8'd4, 8'd4, 8'd4};
    for (int i = 0; i < 4; i++) begin
      send(samp[i], 1'b0, 1'b1, 16'(128 * (i + 1)));
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 20);
      check("latency", lat, TAPS + 1);
      drain();
    end

    // Write during MAC is rejected and coef[1] keeps 0x20: [8,4,4,4] -> 640.
    send(8'd8, 1'b0, 1'b1, 16'd640);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h10;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_busy", {31'h0, cfg_err}, 32'd1);
    @(negedge clk);
    check("cfg_err_pulse_end", {31'h0, cfg_err}, 32'd0);
    drain();
    cfg_write(3'd5, 8'h55);
    @(negedge clk);
    check("cfg_err_addr", {31'h0, cfg_err}, 32'd1);
    tick();

    // Back-pressure: output held for 5 cycles, incoming sample ignored. [2,8,4,4] -> 576.
    out_ready = 1'b0;
    send(8'd2, 1'b0, 1'b1, 16'd576);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, out_valid}, 32'd1);
      check("stall_data",  {16'h0, out_data},  32'd576);
      check("stall_ready", {31'h0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(8'd0, 1'b0, 1'b1, 16'd448);
    drain();

    // Single non-zero tap: extreme products.
    cfg_write(3'd0, 8'h7F);
    @(negedge clk);
    check("cfg_err_ok", {31'h0, cfg_err}, 32'd0);
    tick();
    cfg_write(3'd1, 8'h00);
    cfg_write(3'd2, 8'h00);
    cfg_write(3'd3, 8'h00);
    send(8'h80, 1'b0, 1'b1, 16'hC080);
    drain();
    send(8'h7F, 1'b0, 1'b1, 16'h3F01);
    drain();

    // Reset in the second MAC cycle discards the result and restores coefficients.
    send(8'd5, 1'b0, 1'b0, 16'h0);
    tick();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'h0, in_ready},  32'd1);
    check("midrst_add_b",     {16'h0, add_b},     32'd0);
    tick();
    tick();
    reset = 1'b0;
    send(8'd8, 1'b0, 1'b1, 16'd256);
    drain();

    // Flush alone, flush with a sample, and flush ignored while busy.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(8'd1, 1'b0, 1'b1, 16'd32);
    drain();
    send(8'd3, 1'b1, 1'b1, 16'd96);
    drain();
    send(8'd6, 1'b0, 1'b1, 16'd288);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain();
    send(8'd0, 1'b0, 1'b1, 16'd288);
    drain();

    // Approximate adder: result must follow the adder's output bit for bit.
    cm = '{8'sd3, 8'sd5, 8'sd7, 8'sd9};
    for (int k = 0; k < 4; k++) cfg_write(3'(k), cm[k]);
    approx_mode = 1'b1;
    lm = '{8'sd0, 8'sd6, 8'sd3, 8'sd0};
    samp = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 4; i++) begin
      lm[3] = lm[2]; lm[2] = lm[1]; lm[1] = lm[0]; lm[0] = samp[i];
      e = model(lm, cm);
      send(samp[i], 1'b0, 1'b1, e);
      drain();
    end
    approx_mode = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
